// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared definitions for the programmable synchronous FIFO.
//   DEF_FIFO_WIDTH / DEF_FIFO_DEPTH : default geometry
//   fifo_op_t                       : accepted-operation encoding {write, read}
//   fifo_status_t                   : the seven status flags, packed for monitors
//   next_ptr()                      : pointer increment with explicit wrap
package sync_fifo_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    // Encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_t;

    typedef struct packed {
        logic full;
        logic almostfull;
        logic empty;
        logic almostempty;
        logic overflow;
        logic underflow;
        logic wr_ack;
    } fifo_status_t;

    // Wraps depth-1 -> 0 explicitly so non-power-of-two depths work.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port register array for sync_fifo_prog.
//   clk_i   : rising-edge clock
//   rst_i   : synchronous active-high reset (clears read register only)
//   we_i    : write enable, waddr_i / wdata_i : write address / data
//   re_i    : read enable,  raddr_i           : read address
//   rdata_o : registered read data, holds when re_i is low
// Storage is not reset. A read and write to the same address on one edge
// returns the old contents.
module sync_fifo_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: parametrised synchronous FIFO with arbitrary depth,
// occupancy count, runtime almost-full/almost-empty thresholds and flush.
//   clk, rst (sync, active-high), flush (sync clear, keeps data_out)
//   data_in / wr_en : write side;  rd_en / data_out : read side (1-cycle latency)
//   af_thresh / ae_thresh : almostfull when count >= af, almostempty when count <= ae
//   count, full, empty, almostfull, almostempty : combinational from count
//   overflow, underflow, wr_ack : registered single-cycle pulses
// Optional (macro SYNC_FIFO_PEAK_EN): peak_clr input and peak output tracking
// the maximum count since the last rst/flush.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
`ifdef SYNC_FIFO_PEAK_EN
    input  logic                  peak_clr,
    output logic [CNT_W-1:0]      peak,
`endif
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  wr_ack
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    fifo_status_t status;
    fifo_op_t     op;
    logic         wr_ok, rd_ok;

    always_comb begin
        status             = '0;
        status.full        = (count_q == CNT_W'(FIFO_DEPTH));
        status.empty       = (count_q == '0);
        status.almostfull  = (count_q >= af_thresh);
        status.almostempty = (count_q <= ae_thresh);
        status.overflow    = overflow_q;
        status.underflow   = underflow_q;
        status.wr_ack      = wr_ack_q;
    end

    always_comb begin
        rd_ok = rd_en && !status.empty;
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        wr_ok = wr_en && (!status.full || rd_en);
        op    = fifo_op_t'({wr_ok, rd_ok});

        count_d = count_q;
        case (op)
            OP_WRITE: count_d = count_q + CNT_W'(1);
            OP_READ:  count_d = count_q - CNT_W'(1);
            default:  count_d = count_q;
        endcase

        wr_ptr_d = wr_ok ? PTR_W'(next_ptr(32'(wr_ptr_q), FIFO_DEPTH)) : wr_ptr_q;
        rd_ptr_d = rd_ok ? PTR_W'(next_ptr(32'(rd_ptr_q), FIFO_DEPTH)) : rd_ptr_q;

        wr_ack_d    = wr_ok;
        overflow_d  = wr_en && status.full && !rd_en;
        underflow_d = rd_en && status.empty;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // rst clears data_out inside the memory; flush only blocks the read so
    // data_out keeps its last value.
    sync_fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_ok && !rst && !flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (rd_ok && !flush),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

`ifdef SYNC_FIFO_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    // peak_clr drops the old maximum, but the max rule still applies against
    // the current count, so peak lands on count rather than zero.
    always_comb begin
        peak_d = peak_q;
        if (peak_clr) begin
            peak_d = count_q;
        end else if (count_q > peak_q) begin
            peak_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

    assign count       = count_q;
    assign full        = status.full;
    assign almostfull  = status.almostfull;
    assign empty       = status.empty;
    assign almostempty = status.almostempty;
    assign overflow    = status.overflow;
    assign underflow   = status.underflow;
    assign wr_ack      = status.wr_ack;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed vector bench for sync_fifo_prog (depth 8 and 5).
module tb_sync_fifo_prog;
    import sync_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // depth-8 instance
    logic        rst = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  af_thresh = 4'd6, ae_thresh = 4'd2;
    logic [15:0] data_out;
    logic [3:0]  count;
    logic        full, almostfull, empty, almostempty, overflow, underflow, wr_ack;

    // depth-5 instance
    logic        flush5 = 1'b0, wr5 = 1'b0, rd5 = 1'b0;
    logic [15:0] din5 = '0;
    logic [2:0]  af5 = 3'd4, ae5 = 3'd1;
    logic [15:0] dout5;
    logic [2:0]  count5;
    logic        full5, afull5, empty5, aempty5, ovf5, unf5, ack5;

`ifdef SYNC_FIFO_PEAK_EN
    logic       peak_clr = 1'b0, peak_clr5 = 1'b0;
    logic [3:0] peak;
    logic [2:0] peak5;
`endif

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
`ifdef SYNC_FIFO_PEAK_EN
        .peak_clr(peak_clr), .peak(peak),
`endif
        .data_out(data_out), .count(count), .full(full), .almostfull(almostfull),
        .empty(empty), .almostempty(almostempty), .overflow(overflow),
        .underflow(underflow), .wr_ack(wr_ack)
    );

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .data_in(din5), .wr_en(wr5), .rd_en(rd5),
        .flush(flush5), .af_thresh(af5), .ae_thresh(ae5),
`ifdef SYNC_FIFO_PEAK_EN
        .peak_clr(peak_clr5), .peak(peak5),
`endif
        .data_out(dout5), .count(count5), .full(full5), .almostfull(afull5),
        .empty(empty5), .almostempty(aempty5), .overflow(ovf5),
        .underflow(unf5), .wr_ack(ack5)
    );

    typedef struct {
        logic         rst, flush, wr, rd;
        logic [15:0]  din;
        logic [3:0]   af, ae;
        logic [3:0]   cnt;
        logic [15:0]  dout;
        fifo_status_t st;
    } vec_t;

    vec_t        tab[$];
    logic [3:0]  tab_af, tab_ae;
    int unsigned nvec = 0, nerr = 0;

    function automatic void v(logic r, logic f, logic w, logic rd, logic [15:0] din,
                              logic [3:0] cnt, logic [15:0] dout,
                              logic ovf, logic unf, logic ack);
        vec_t t;
        t.rst = r; t.flush = f; t.wr = w; t.rd = rd; t.din = din;
        t.af = tab_af; t.ae = tab_ae; t.cnt = cnt; t.dout = dout;
        t.st.full        = (cnt == 4'd8);
        t.st.almostfull  = (cnt >= tab_af);
        t.st.empty       = (cnt == 4'd0);
        t.st.almostempty = (cnt <= tab_ae);
        t.st.overflow    = ovf;
        t.st.underflow   = unf;
        t.st.wr_ack      = ack;
        tab.push_back(t);
    endfunction

    function automatic void vw(logic [15:0] din, logic [3:0] cnt, logic [15:0] dout);
        v(0, 0, 1, 0, din, cnt, dout, 0, 0, 1);
    endfunction

    function automatic void vr(logic [3:0] cnt, logic [15:0] dout);
        v(0, 0, 0, 1, 16'h0, cnt, dout, 0, 0, 0);
    endfunction

    function automatic void vi(logic [3:0] cnt, logic [15:0] dout);
        v(0, 0, 0, 0, 16'h0, cnt, dout, 0, 0, 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    initial begin
        fifo_status_t got_st;

        tab_af = 4'd6;
        tab_ae = 4'd2;
        v(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0);             // reset
        for (int i = 1; i <= 3; i++) vw(16'(i), 4'(i), 16'h0);
        v(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0);             // mid-operation reset
        for (int i = 1; i <= 8; i++) vw(16'(i), 4'(i), 16'h0);
        v(0, 0, 1, 0, 16'hDEAD, 8, 16'h0, 1, 0, 0);          // overflow
        vi(8, 16'h0);                                         // overflow is a pulse
        for (int i = 1; i <= 8; i++) vr(4'(8 - i), 16'(i));
        v(0, 0, 0, 1, 16'h0, 0, 16'h8, 0, 1, 0);             // underflow, data_out holds
        vi(0, 16'h8);
        v(0, 0, 1, 1, 16'h0055, 1, 16'h8, 0, 1, 1);          // both while empty
        for (int i = 2; i <= 8; i++) vw(16'(16'h10 + i), 4'(i), 16'h8);
        v(0, 0, 1, 1, 16'h00AA, 8, 16'h0055, 0, 0, 1);       // both while full
        for (int i = 2; i <= 8; i++) vr(4'(9 - i), 16'(16'h10 + i));
        vr(0, 16'h00AA);
        for (int i = 1; i <= 4; i++) vw(16'(16'h20 + i), 4'(i), 16'h00AA);
        tab_af = 4'd3; vi(4, 16'h00AA);
        tab_af = 4'd0; vi(4, 16'h00AA);                       // af=0 forces almostfull
        tab_af = 4'd6; tab_ae = 4'd8; vi(4, 16'h00AA);        // ae>=depth forces almostempty
        tab_ae = 4'd2;
        for (int i = 5; i <= 7; i++) vw(16'(16'h20 + i), 4'(i), 16'h00AA);
        v(0, 1, 1, 0, 16'hBEEF, 0, 16'h00AA, 0, 0, 0);       // flush beats write
        vi(0, 16'h00AA);
        vw(16'h0031, 1, 16'h00AA);
        vr(0, 16'h0031);

        for (int i = 0; i < tab.size(); i++) begin
            rst = tab[i].rst; flush = tab[i].flush; wr_en = tab[i].wr; rd_en = tab[i].rd;
            data_in = tab[i].din; af_thresh = tab[i].af; ae_thresh = tab[i].ae;
            step();
            got_st = {full, almostfull, empty, almostempty, overflow, underflow, wr_ack};
            nvec++;
            if ({count, data_out, got_st} !== {tab[i].cnt, tab[i].dout, tab[i].st}) begin
                nerr++;
                $display("FAIL vec%0d: count=%0d data_out=0x%0h flags=%b expected count=%0d data_out=0x%0h flags=%b",
                         i, count, data_out, got_st, tab[i].cnt, tab[i].dout, tab[i].st);
            end
        end
        rst = 0; flush = 0; wr_en = 0; rd_en = 0;

        // Threshold change takes effect without a clock edge.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; data_in = 16'(16'h40 + i);
            step();
        end
        wr_en = 0;
        chk("af_before", {31'b0, almostfull}, 32'd0);
        af_thresh = 4'd3;
        #1;
        chk("af_same_cycle", {31'b0, almostfull}, 32'd1);
        ae_thresh = 4'd4;
        #1;
        chk("ae_same_cycle", {31'b0, almostempty}, 32'd1);
        af_thresh = 4'd6; ae_thresh = 4'd2;

        // Depth-5 wrap: prefill 3, then 20 simultaneous read/write cycles.
        for (int k = 0; k < 3; k++) begin
            wr5 = 1; din5 = 16'(16'h100 + k);
            step();
            chk("d5_fill_count", 32'(count5), 32'(k + 1));
        end
        for (int j = 0; j < 20; j++) begin
            wr5 = 1; rd5 = 1; din5 = 16'(16'h103 + j);
            step();
            chk("d5_wrap_data", 32'(dout5), 32'(16'h100 + j));
            chk("d5_wrap_count", 32'(count5), 32'd3);
        end
        rd5 = 0;
        din5 = 16'h117; step();
        din5 = 16'h118; step();
        chk("d5_full", {28'b0, count5, full5}, {28'b0, 3'd5, 1'b1});
        din5 = 16'h119; step();
        chk("d5_overflow", {28'b0, count5, ovf5}, {28'b0, 3'd5, 1'b1});
        wr5 = 0;
        for (int k = 0; k < 5; k++) begin
            rd5 = 1;
            step();
            chk("d5_drain", 32'(dout5), 32'(16'h114 + k));
        end
        rd5 = 0;
        step();
        chk("d5_empty", {31'b0, empty5}, 32'd1);

`ifdef SYNC_FIFO_PEAK_EN
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1; data_in = 16'(16'h60 + i);
            step();
        end
        wr_en = 0;
        step();
        chk("peak7", 32'(peak), 32'd7);
        flush = 1; step(); flush = 0;
        chk("flush_count", {27'b0, count, empty}, {27'b0, 4'd0, 1'b1});
        chk("flush_peak", 32'(peak), 32'd0);
        for (int i = 0; i < 2; i++) begin
            wr_en = 1; data_in = 16'(16'h70 + i);
            step();
        end
        wr_en = 0;
        step();
        chk("peak2", 32'(peak), 32'd2);
        wr_en = 1; data_in = 16'h0072; step(); wr_en = 0;
        rd_en = 1; step(); rd_en = 0;
        peak_clr = 1; step(); peak_clr = 0;
        chk("peak_clr_max", 32'(peak), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
